// File: rtl/lzss_pkg.sv
// lzss_pkg: codeword field layout, match length limits and FSM states shared by the LZSS encoder and decoder.
package lzss_pkg;
  localparam int OFF_W = 7;
  localparam int LEN_W = 3;
  localparam int MIN_LEN = 2;
  localparam int MAX_LEN = 5;
  localparam int FLAG_BIT = 10;
  localparam int OFF_MSB = 9;
  localparam int OFF_LSB = 3;
  localparam int LEN_MSB = 2;
  localparam int LEN_LSB = 0;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_COPY, S_EMIT, S_FLUSH, S_DONE} state_t;
endpackage

// File: rtl/lzss_hist_buf.sv
// lzss_hist_buf: circular byte history with write pointer, asynchronous back-reference read and synchronous write.
module lzss_hist_buf
  import lzss_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             clr,
  input  logic [7:0]       wdata,
  input  logic [OFF_W-1:0] off,
  output logic [7:0]       rdata
);
  logic [7:0] mem [2**OFF_W];
  logic [OFF_W-1:0] wp, ra;
  assign ra = wp - off - OFF_W'(1);
  assign rdata = mem[ra];
  always_ff @(posedge clk or posedge reset)
    if (reset) wp <= '0;
    else if (clr) wp <= '0;
    else if (we) wp <= wp + OFF_W'(1);
  always_ff @(posedge clk)
    if (we) mem[wp] <= wdata;
endmodule

// File: rtl/lzss_decoder.sv
// lzss_decoder: expands 11-bit LZSS codewords into packed 32-bit words; LZSS_CHECK_EN builds the sticky codeword checker.
module lzss_decoder
  import lzss_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] total_num,
  input  logic [10:0] codeword,
  input  logic        cw_valid,
  output logic        cw_ready,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic [2:0]  data_bytes,
  output logic        finish,
  output logic        error
);
  state_t state, nxt;
  logic [11:0] tot, cnt;
  logic [10:0] cw;
  logic [LEN_W-1:0] rem, byte_cnt, raw_len, len;
  logic [31:0] word;
  logic [7:0] hist_byte, byte_val;
  logic go, accept, copy, last_cw, flush_v, drain;
  assign go = start && (state == S_IDLE || state == S_DONE);
  assign accept = state == S_FETCH && cw_valid;
  assign copy = state == S_COPY;
  assign raw_len = codeword[LEN_MSB:LEN_LSB];
  assign len = raw_len == '0 ? LEN_W'(1) : raw_len;
  assign byte_val = cw[FLAG_BIT] ? hist_byte : cw[7:0];
  assign last_cw = cnt == tot;
  assign flush_v = state == S_FLUSH && byte_cnt != '0;
  assign drain = (state == S_EMIT || flush_v) && data_ready;
  assign cw_ready = state == S_FETCH;
  assign data_valid = state == S_EMIT || flush_v;
  assign data_bytes = state == S_EMIT ? 3'd4 : flush_v ? byte_cnt : 3'd0;
  assign data_out = word;
  assign finish = state == S_DONE;
  lzss_hist_buf u_hist (
    .clk(clk), .reset(reset), .we(copy), .clr(go), .wdata(byte_val),
    .off(cw[OFF_MSB:OFF_LSB]), .rdata(hist_byte)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) nxt = total_num == '0 ? S_DONE : S_FETCH;
      S_FETCH: if (cw_valid) nxt = S_COPY;
      S_COPY: nxt = byte_cnt == 3'd3 ? S_EMIT : rem == LEN_W'(1) ? (last_cw ? S_FLUSH : S_FETCH) : S_COPY;
      S_EMIT: if (data_ready) nxt = rem != '0 ? S_COPY : last_cw ? S_FLUSH : S_FETCH;
      S_FLUSH: if (byte_cnt == '0 || data_ready) nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tot <= '0;
      cnt <= '0;
      cw <= '0;
      rem <= '0;
      byte_cnt <= '0;
      word <= '0;
    end else begin
      if (go) begin
        tot <= total_num;
        cnt <= '0;
        rem <= '0;
        byte_cnt <= '0;
        word <= '0;
      end
      if (accept) begin
        cw <= codeword;
        rem <= codeword[FLAG_BIT] ? len : LEN_W'(1);
        cnt <= cnt + 12'd1;
      end
      if (copy) begin
        word[{byte_cnt[1:0], 3'b000} +: 8] <= byte_val;
        byte_cnt <= byte_cnt + LEN_W'(1);
        rem <= rem - LEN_W'(1);
      end
      if (drain) begin
        byte_cnt <= '0;
        word <= '0;
      end
    end
`ifdef LZSS_CHECK_EN
  logic [7:0] dec;
  logic err, bad;
  // dec saturates at the history depth: any distance is legal once 128 bytes exist
  assign bad = codeword[FLAG_BIT]
             ? (raw_len < LEN_W'(MIN_LEN) || raw_len > LEN_W'(MAX_LEN) ||
                {1'b0, codeword[OFF_MSB:OFF_LSB]} + 8'd1 > dec)
             : codeword[9:8] != 2'b00;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dec <= '0;
      err <= 1'b0;
    end else if (go) begin
      dec <= '0;
      err <= 1'b0;
    end else begin
      if (copy && !dec[7]) dec <= dec + 8'd1;
      if (accept && bad) err <= 1'b1;
    end
  assign error = err;
`else
  assign error = 1'b0;
`endif
endmodule
